core_mem_responder: RTL and testbench

- Memory-side responder for the core's req/gnt memory interface; one instance serves imem, a second serves dmem.
- Backed by a local byte-strobed word store with programmable wait states and address-range error generation.
- Monitors initiator protocol rules and flags violations.
- Used in core simulation benches and as the concrete memory model behind the formal fairness environment.

---
 rtl/core_mem_pkg.sv | 33 +++
 rtl/core_mem_responder_if.sv | 25 ++
 rtl/core_mem_store.sv | 29 ++
 rtl/core_mem_responder.sv | 137 +++++++++++++
 tb/tb_core_mem_responder.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/core_mem_pkg.sv
// Shared types and address helpers for the core memory responder and its store.
package core_mem_pkg;

  localparam int unsigned WAIT_CNT_W = 4;
  localparam int unsigned ADDR_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  // Word index relative to the store base; bits below word alignment drop out.
  function automatic logic [ADDR_MAX_W-1:0] word_index(
    input logic [ADDR_MAX_W-1:0] addr,
    input logic [ADDR_MAX_W-1:0] base,
    input int unsigned           off_w
  );
    return (addr - base) >> off_w;
  endfunction

  function automatic logic addr_out_of_range(
    input logic [ADDR_MAX_W-1:0] addr,
    input logic [ADDR_MAX_W-1:0] base,
    input int unsigned           off_w,
    input int unsigned           depth_w
  );
    logic [ADDR_MAX_W-1:0] idx;
    idx = word_index(addr, base, off_w);
    return (addr < base) || ((idx >> depth_w) != '0);
  endfunction

endpackage

// File: rtl/core_mem_responder_if.sv
// req/gnt memory bus between a core-side initiator and a memory-side responder.
interface core_mem_responder_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned STRB_W = 8,
  parameter int unsigned DATA_W = 8 * STRB_W
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [STRB_W-1:0] mem_strb;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_err;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_addr, mem_wen, mem_strb, mem_wdata,
    input  mem_gnt, mem_err, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr, mem_wen, mem_strb, mem_wdata,
    output mem_gnt, mem_err, mem_rdata
  );
endinterface

// File: rtl/core_mem_store.sv
// Byte-strobed synchronous word store: one registered read port, one write port.
module core_mem_store #(
  parameter int unsigned DEPTH_W = 10,
  parameter int unsigned STRB_W  = 8,
  parameter int unsigned DATA_W  = 8 * STRB_W
) (
  input  logic               clk,
  input  logic               we,
  input  logic [DEPTH_W-1:0] waddr,
  input  logic [STRB_W-1:0]  wstrb,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [DEPTH_W-1:0] raddr,
  output logic [DATA_W-1:0]  rdata
);

  logic [DATA_W-1:0] mem_array [2**DEPTH_W];

  // NOTE: the array and its read register carry no reset so they map onto
  // block RAM; consumers must qualify rdata before using it.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (wstrb[b]) mem_array[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    rdata <= mem_array[raddr];
  end

endmodule

// File: rtl/core_mem_responder.sv
// Memory-side responder for the core req/gnt bus: wait states, range/injected
// errors, initiator protocol monitoring and a completed-response counter.
module core_mem_responder
  import core_mem_pkg::*;
#(
  parameter int unsigned          MEM_ADDR_W = 64,
  parameter int unsigned          MEM_STRB_W = 8,
  parameter int unsigned          MEM_DATA_W = 8 * MEM_STRB_W,
  parameter int unsigned          DEPTH_W    = 10,
  parameter logic [ADDR_MAX_W-1:0] BASE_ADDR = 64'h0
) (
  input  logic                  f_clk,
  input  logic                  g_reset,
  core_mem_responder_if.slave   mem,
  input  logic [WAIT_CNT_W-1:0] cfg_wait,
  input  logic                  cfg_err_inj,
  output logic                  proto_err,
  output logic [31:0]           req_count
);

  localparam int unsigned OFF_W = $clog2(MEM_STRB_W);

  mem_state_t              state, next_state;
  logic [WAIT_CNT_W-1:0]   cnt;
  logic [MEM_ADDR_W-1:0]   addr_q;
  logic                    wen_q;
  logic [MEM_STRB_W-1:0]   strb_q;
  logic [MEM_DATA_W-1:0]   wdata_q;
  logic                    inj_q;

  logic [DEPTH_W-1:0]      live_idx, hold_idx, rd_idx;
  logic                    hold_range_err;
  logic                    drop_viol, chg_viol;
  logic                    gnt, resp_err, store_we;
  logic [MEM_DATA_W-1:0]   rdata_out;
  logic [MEM_DATA_W-1:0]   store_q;

  assign live_idx = DEPTH_W'(word_index(ADDR_MAX_W'(mem.mem_addr), BASE_ADDR, OFF_W));
  assign hold_idx = DEPTH_W'(word_index(ADDR_MAX_W'(addr_q), BASE_ADDR, OFF_W));
  assign hold_range_err = addr_out_of_range(ADDR_MAX_W'(addr_q), BASE_ADDR, OFF_W, DEPTH_W);

  // The read is issued one cycle ahead of RESP: from the live bus when leaving
  // IDLE directly, otherwise from the captured address.
  assign rd_idx = (state == IDLE) ? live_idx : hold_idx;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge f_clk or posedge g_reset) begin
    if (g_reset) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state logic and protocol monitor
  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    next_state = state;
    drop_viol  = 1'b0;
    chg_viol   = 1'b0;
    unique case (state)
      IDLE: if (mem.mem_req) next_state = (cfg_wait == '0) ? RESP : WAIT;
      WAIT: begin
        if (!mem.mem_req) begin
          drop_viol  = 1'b1;
          next_state = IDLE;
        end else begin
          chg_viol = (mem.mem_addr  != addr_q) || (mem.mem_wen  != wen_q) ||
                     (mem.mem_strb  != strb_q) || (mem.mem_wdata != wdata_q);
          if (cnt == WAIT_CNT_W'(1)) next_state = RESP;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    gnt       = (state == RESP);
    resp_err  = gnt && (hold_range_err || inj_q);
    store_we  = gnt && wen_q && !resp_err && !g_reset;
    rdata_out = (gnt && !wen_q && !resp_err) ? store_q : '0;
  end

  assign mem.mem_gnt   = gnt;
  assign mem.mem_err   = resp_err;
  assign mem.mem_rdata = rdata_out;

  // Request capture and wait counter
  always_ff @(posedge f_clk or posedge g_reset) begin
    if (g_reset) begin
      cnt     <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      strb_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && mem.mem_req) begin
      cnt     <= cfg_wait;
      addr_q  <= mem.mem_addr;
      wen_q   <= mem.mem_wen;
      strb_q  <= mem.mem_strb;
      wdata_q <= mem.mem_wdata;
    end else if (state == WAIT) begin
      cnt <= cnt - WAIT_CNT_W'(1);
    end
  end

  // Sticky status, response counter and error-injection latch
  always_ff @(posedge f_clk or posedge g_reset) begin
    if (g_reset) begin
      proto_err <= 1'b0;
      req_count <= '0;
      inj_q     <= 1'b0;
    end else begin
      if (drop_viol || chg_viol) proto_err <= 1'b1;
      if (state == RESP)         req_count <= req_count + 32'd1;
      // A new injection in the consuming cycle wins over the clear.
      if (cfg_err_inj)           inj_q <= 1'b1;
      else if (state == RESP)    inj_q <= 1'b0;
    end
  end

  core_mem_store #(
    .DEPTH_W (DEPTH_W),
    .STRB_W  (MEM_STRB_W),
    .DATA_W  (MEM_DATA_W)
  ) u_store (
    .clk   (f_clk),
    .we    (store_we),
    .waddr (hold_idx),
    .wstrb (strb_q),
    .wdata (wdata_q),
    .raddr (rd_idx),
    .rdata (store_q)
  );

endmodule

// File: tb/tb_core_mem_responder.sv
// Directed table-driven bench for core_mem_responder plus multi-cycle corner sequences.
module tb_core_mem_responder;

  logic        f_clk;
  logic        g_reset;
  logic [3:0]  cfg_wait;
  logic        cfg_err_inj;
  logic        proto_err;
  logic [31:0] req_count;

  int total = 0;
  int bad   = 0;
  int exp_count = 0;

  core_mem_responder_if #(.ADDR_W(64), .STRB_W(8), .DATA_W(64)) bus ();

  core_mem_responder #(
    .MEM_ADDR_W (64),
    .MEM_STRB_W (8),
    .MEM_DATA_W (64),
    .DEPTH_W    (10),
    .BASE_ADDR  (64'h0)
  ) dut (
    .f_clk       (f_clk),
    .g_reset     (g_reset),
    .mem         (bus.slave),
    .cfg_wait    (cfg_wait),
    .cfg_err_inj (cfg_err_inj),
    .proto_err   (proto_err),
    .req_count   (req_count)
  );

  initial f_clk = 1'b0;
  always #5 f_clk = ~f_clk;

  typedef struct {
    logic        wen;
    logic [63:0] addr;
    logic [7:0]  strb;
    logic [63:0] wdata;
    logic [3:0]  wt;
    int          exp_lat;
    logic        exp_err;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic wen, input logic [63:0] addr, input logic [7:0] strb,
                     input logic [63:0] wdata, input logic [3:0] wt, input int lat,
                     input logic err, input logic [63:0] rd);
    vec_t v;
    v.wen = wen; v.addr = addr; v.strb = strb; v.wdata = wdata; v.wt = wt;
    v.exp_lat = lat; v.exp_err = err; v.exp_rdata = rd;
    vecs.push_back(v);
  endtask

  // One complete transaction; lat=0 means no grant within the budget.
  task automatic do_req(input logic wen, input logic [63:0] addr, input logic [7:0] strb,
                        input logic [63:0] wdata, input logic [3:0] wt,
                        output int lat, output logic err, output logic [63:0] rdata);
    @(negedge f_clk);
    bus.mem_req = 1'b1; bus.mem_wen = wen; bus.mem_addr = addr;
    bus.mem_strb = strb; bus.mem_wdata = wdata; cfg_wait = wt;
    lat = 0; err = 1'b0; rdata = '0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge f_clk); #1;
      if (bus.mem_gnt) begin
        lat = i; err = bus.mem_err; rdata = bus.mem_rdata;
        break;
      end
    end
    bus.mem_req = 1'b0;
    @(posedge f_clk); #1;
  endtask

  initial begin
    int          lat;
    logic        err;
    logic [63:0] rd;
    logic        seen_gnt;

    g_reset = 1'b1; cfg_wait = '0; cfg_err_inj = 1'b0;
    bus.mem_req = 1'b0; bus.mem_wen = 1'b0; bus.mem_addr = '0;
    bus.mem_strb = '0; bus.mem_wdata = '0;

    // Zero-wait reads are one cycle; strobed writes merge bytes; index 1024
    // (byte 8192) is out of range and aliases word 0 if not suppressed.
    add(1, 64'd40,   8'hFF, 64'hDEAD_BEEF_0123_4567, 4'd0,  1, 0, 64'h0);
    add(0, 64'd40,   8'h00, 64'h0,                   4'd0,  1, 0, 64'hDEAD_BEEF_0123_4567);
    add(1, 64'd8,    8'hFF, 64'hAAAA_AAAA_AAAA_AAAA, 4'd0,  1, 0, 64'h0);
    add(1, 64'd8,    8'h0F, 64'h1111_2222_3333_4444, 4'd3,  4, 0, 64'h0);
    add(0, 64'd8,    8'h00, 64'h0,                   4'd3,  4, 0, 64'hAAAA_AAAA_3333_4444);
    add(0, 64'd13,   8'h00, 64'h0,                   4'd1,  2, 0, 64'hAAAA_AAAA_3333_4444);
    add(1, 64'd8,    8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 4'd0,  1, 0, 64'h0);
    add(0, 64'd8,    8'h00, 64'h0,                   4'd2,  3, 0, 64'hAAAA_AAAA_3333_4444);
    add(1, 64'd0,    8'hFF, 64'h0F0F_0F0F_0F0F_0F0F, 4'd0,  1, 0, 64'h0);
    add(0, 64'd8192, 8'h00, 64'h0,                   4'd0,  1, 1, 64'h0);
    add(1, 64'd8192, 8'hFF, 64'h5555_5555_5555_5555, 4'd0,  1, 1, 64'h0);
    add(0, 64'd0,    8'h00, 64'h0,                   4'd0,  1, 0, 64'h0F0F_0F0F_0F0F_0F0F);
    add(1, 64'd16,   8'hFF, 64'h0,                   4'd0,  1, 0, 64'h0);
    add(1, 64'd16,   8'h81, 64'h1122_3344_5566_7788, 4'd0,  1, 0, 64'h0);
    add(0, 64'd16,   8'h00, 64'h0,                   4'd4,  5, 0, 64'h1100_0000_0000_0088);
    add(1, 64'd8184, 8'hFF, 64'h0123_4567_89AB_CDEF, 4'd0,  1, 0, 64'h0);
    add(0, 64'd8184, 8'h00, 64'h0,                   4'd0,  1, 0, 64'h0123_4567_89AB_CDEF);
    add(0, 64'd40,   8'h00, 64'h0,                   4'd15, 16, 0, 64'hDEAD_BEEF_0123_4567);

    #12;
    check("reset_gnt",   {63'd0, bus.mem_gnt}, 64'd0);
    check("reset_err",   {63'd0, bus.mem_err}, 64'd0);
    check("reset_rdata", bus.mem_rdata, 64'd0);
    check("reset_proto", {63'd0, proto_err}, 64'd0);
    check("reset_count", {32'd0, req_count}, 64'd0);
    @(negedge f_clk); g_reset = 1'b0;

    foreach (vecs[k]) begin
      do_req(vecs[k].wen, vecs[k].addr, vecs[k].strb, vecs[k].wdata, vecs[k].wt, lat, err, rd);
      exp_count++;
      check($sformatf("v%0d_lat", k),   64'(lat), 64'(vecs[k].exp_lat));
      check($sformatf("v%0d_err", k),   {63'd0, err}, {63'd0, vecs[k].exp_err});
      check($sformatf("v%0d_rdata", k), rd, vecs[k].exp_rdata);
    end
    check("count_after_table", {32'd0, req_count}, 64'(exp_count));

    // Error injection: a pulse poisons exactly one response.
    @(negedge f_clk); cfg_err_inj = 1'b1;
    @(negedge f_clk); cfg_err_inj = 1'b0;
    do_req(0, 64'd40, 8'h00, 64'h0, 4'd0, lat, err, rd); exp_count++;
    check("inj1_err",   {63'd0, err}, 64'd1);
    check("inj1_rdata", rd, 64'd0);
    do_req(0, 64'd40, 8'h00, 64'h0, 4'd0, lat, err, rd); exp_count++;
    check("inj2_err",   {63'd0, err}, 64'd0);
    check("inj2_rdata", rd, 64'hDEAD_BEEF_0123_4567);
    // Injection held through the consuming response keeps the latch set.
    cfg_err_inj = 1'b1;
    do_req(0, 64'd40, 8'h00, 64'h0, 4'd1, lat, err, rd); exp_count++;
    check("inj_hold1_err", {63'd0, err}, 64'd1);
    cfg_err_inj = 1'b0;
    do_req(0, 64'd40, 8'h00, 64'h0, 4'd0, lat, err, rd); exp_count++;
    check("inj_hold2_err", {63'd0, err}, 64'd1);
    do_req(0, 64'd40, 8'h00, 64'h0, 4'd0, lat, err, rd); exp_count++;
    check("inj_hold3_err", {63'd0, err}, 64'd0);

    // Dropped request during WAIT: abort, no grant, sticky proto_err.
    @(negedge f_clk);
    bus.mem_req = 1'b1; bus.mem_wen = 1'b1; bus.mem_addr = 64'd40;
    bus.mem_strb = 8'hFF; bus.mem_wdata = 64'h7777_7777_7777_7777; cfg_wait = 4'd5;
    seen_gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge f_clk); #1;
      if (bus.mem_gnt) seen_gnt = 1'b1;
    end
    bus.mem_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge f_clk); #1;
      if (bus.mem_gnt) seen_gnt = 1'b1;
    end
    check("drop_no_gnt", {63'd0, seen_gnt}, 64'd0);
    check("drop_proto",  {63'd0, proto_err}, 64'd1);
    check("drop_count",  {32'd0, req_count}, 64'(exp_count));
    do_req(0, 64'd40, 8'h00, 64'h0, 4'd0, lat, err, rd); exp_count++;
    check("drop_next_lat",   64'(lat), 64'd1);
    check("drop_next_rdata", rd, 64'hDEAD_BEEF_0123_4567);
    check("drop_proto_sticky", {63'd0, proto_err}, 64'd1);

    // Asynchronous reset while a write waits.
    @(negedge f_clk);
    bus.mem_req = 1'b1; bus.mem_wen = 1'b1; bus.mem_addr = 64'd40;
    bus.mem_strb = 8'hFF; bus.mem_wdata = 64'hBADB_ADBA_DBAD_BADB; cfg_wait = 4'd5;
    @(posedge f_clk); #1;
    @(posedge f_clk); #3;
    g_reset = 1'b1;
    #1;
    check("rst_gnt",   {63'd0, bus.mem_gnt}, 64'd0);
    check("rst_err",   {63'd0, bus.mem_err}, 64'd0);
    check("rst_rdata", bus.mem_rdata, 64'd0);
    check("rst_proto", {63'd0, proto_err}, 64'd0);
    check("rst_count", {32'd0, req_count}, 64'd0);
    @(negedge f_clk); g_reset = 1'b0; bus.mem_req = 1'b0;
    exp_count = 0;
    do_req(0, 64'd40, 8'h00, 64'h0, 4'd0, lat, err, rd); exp_count++;
    check("rst_word_kept", rd, 64'hDEAD_BEEF_0123_4567);

    // Fields and cfg_wait change mid-WAIT: response uses the captured request.
    @(negedge f_clk);
    bus.mem_req = 1'b1; bus.mem_wen = 1'b1; bus.mem_addr = 64'd24;
    bus.mem_strb = 8'hFF; bus.mem_wdata = 64'h1234_5678_9ABC_DEF0; cfg_wait = 4'd3;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge f_clk); #1;
      if (i == 1) begin
        bus.mem_wdata = 64'h9999_9999_9999_9999;
        bus.mem_addr  = 64'd32;
        cfg_wait      = 4'd0;
      end
      if (bus.mem_gnt) begin
        lat = i;
        break;
      end
    end
    bus.mem_req = 1'b0;
    @(posedge f_clk); #1;
    exp_count++;
    check("chg_lat",   64'(lat), 64'd4);
    check("chg_proto", {63'd0, proto_err}, 64'd1);
    do_req(0, 64'd24, 8'h00, 64'h0, 4'd0, lat, err, rd); exp_count++;
    check("chg_captured_data", rd, 64'h1234_5678_9ABC_DEF0);
    check("final_count", {32'd0, req_count}, 64'(exp_count));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
